// File: rtl/load_use_scoreboard_if.sv
// rtl/load_use_scoreboard_if.sv - decode-side port bundle for the load-use scoreboard
interface load_use_scoreboard_if #(
  parameter int NUM_SRC = 2,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 32
);
  logic [NUM_SRC-1:0]       src_en;
  logic [NUM_SRC*REG_W-1:0] src_req;
  logic                     issue_valid;
  logic                     issue_mem_read;
  logic [REG_W-1:0]         issue_req_w;
  logic                     flush;
  logic                     bubble;
  logic [2:0]               pending_cnt;
  logic [CNT_W-1:0]         stall_count;

  modport master (
    output src_en, src_req, issue_valid, issue_mem_read, issue_req_w, flush,
    input  bubble, pending_cnt, stall_count
  );

  modport slave (
    input  src_en, src_req, issue_valid, issue_mem_read, issue_req_w, flush,
    output bubble, pending_cnt, stall_count
  );
endinterface

// File: rtl/load_use_scoreboard.sv
// rtl/load_use_scoreboard.sv - multi-cycle load-use hazard detector with flush and stall counter
module load_use_scoreboard #(
  parameter int NUM_SRC  = 2,
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 32
) (
  input logic                  clk,
  input logic                  rst,
  load_use_scoreboard_if.slave bus
);
  logic [LOAD_LAT-1:0] ent_v;
  logic [LOAD_LAT-1:0] ent_v_next;
  logic [REG_W-1:0]    ent_reg [LOAD_LAT];
  logic                hazard;
  logic                insert_v;
  logic [2:0]          pop_next;
  logic [2:0]          pending_q;
  logic [CNT_W-1:0]    stall_q;

  // Compare every enabled, non-zero source operand against every in-flight load destination.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < LOAD_LAT; k++) begin
        if (bus.src_en[i] && (bus.src_req[i*REG_W +: REG_W] != '0) && ent_v[k] &&
            (ent_reg[k] == bus.src_req[i*REG_W +: REG_W])) begin
          hazard = 1'b1;
        end
      end
    end
  end

  assign bus.bubble = bus.issue_valid & hazard;

  // A stalled load re-presents next cycle, so it must not enter while bubble is high.
  assign insert_v = bus.issue_valid & bus.issue_mem_read & (bus.issue_req_w != '0) &
                    ~bus.bubble & ~bus.flush;

  // Next valid vector: shift toward retirement, or drop everything on flush.
  always_comb begin
    ent_v_next = '0;
    if (!bus.flush) begin
      for (int k = LOAD_LAT - 1; k > 0; k--) begin
        ent_v_next[k] = ent_v[k-1];
      end
      ent_v_next[0] = insert_v;
    end
  end

  // Population count of the post-edge scoreboard, registered as pending_cnt.
  always_comb begin
    pop_next = '0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      pop_next = pop_next + {2'b00, ent_v_next[k]};
    end
  end

  // Valid bits and pending count; reset empties the scoreboard.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_v     <= '0;
      pending_q <= '0;
    end else begin
      ent_v     <= ent_v_next;
      pending_q <= pop_next;
    end
  end

  // Register numbers are only meaningful where v is set, so they shift unconditionally.
  always_ff @(posedge clk) begin
    ent_reg[0] <= bus.issue_req_w;
    for (int k = 1; k < LOAD_LAT; k++) begin
      ent_reg[k] <= ent_reg[k-1];
    end
  end

  // Saturating stall-cycle counter; flush leaves it alone, reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (bus.bubble && (stall_q != '1)) begin
      stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.pending_cnt = pending_q;
  assign bus.stall_count = stall_q;
endmodule
